// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared FSM type, default sizing and effective-N helper for spectrum_averager
package spectrum_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;
  localparam int FFT_WIDTH_DFLT = 12;
  localparam int NBINS = 2**FFT_WIDTH_DFLT;
  function automatic logic [31:0] eff_n(input logic [31:0] n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction
endpackage

// File: rtl/spectrum_averager_if.sv
// spectrum_averager_if: power-sample input stream and averaged-frame output stream
interface spectrum_averager_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH = 48
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic s_axis_tvalid;
  logic [ACC_WIDTH-1:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  modport master (output s_axis_tdata, s_axis_tvalid, input m_axis_tdata, m_axis_tvalid, m_axis_tlast);
  modport slave (input s_axis_tdata, s_axis_tvalid, output m_axis_tdata, m_axis_tvalid, m_axis_tlast);
endinterface

// File: rtl/spectrum_averager_accum_ram.sv
// accum_ram: simple dual-port accumulator RAM with registered read, shaped for BRAM inference
module accum_ram import spectrum_pkg::*; #(
  parameter int DEPTH = NBINS,
  parameter int WIDTH = 48,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/spectrum_averager.sv
// spectrum_averager: sums N consecutive power-spectrum frames per bin and emits the raw sum frame.
// Optional SPECTRUM_AVERAGER_SATURATE_EN clamps the adder and adds a sticky sat_flag output.
module spectrum_averager import spectrum_pkg::*; #(
  parameter int FFT_WIDTH = FFT_WIDTH_DFLT,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH = 48,
  parameter int N_AVG_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   avg_en,
  input  logic [N_AVG_WIDTH-1:0] cfg_n_avg,
  spectrum_averager_if.slave     bus,
  output logic [N_AVG_WIDTH-1:0] n_avg_used,
  output logic [31:0]            avg_count
`ifdef SPECTRUM_AVERAGER_SATURATE_EN
  , output logic                 sat_flag
`endif
);
  localparam logic [FFT_WIDTH-1:0] LAST = '1;
  localparam logic [N_AVG_WIDTH-1:0] ONE = N_AVG_WIDTH'(1);
  state_e state_q;
  logic [FFT_WIDTH-1:0] addr_q, s1_addr_q, s2_addr_q;
  logic [N_AVG_WIDTH-1:0] k_q, n_q, k_eff, n_eff, n_cfg;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [ACC_WIDTH-1:0] rd_data, sum, s2_sum_q, m_data_q;
  logic [31:0] cnt_q;
  logic s1_vld_q, s1_first_q, s1_emit_q, s1_last_q, s2_vld_q, m_vld_q, m_last_q;
  logic start, proc, emit, last;
  assign n_cfg = N_AVG_WIDTH'(eff_n(32'(cfg_n_avg)));
  assign start = avg_en && bus.s_axis_tvalid && state_q == ARM && addr_q == '0;
  assign proc = start || (avg_en && bus.s_axis_tvalid && state_q == RUN);
  assign k_eff = start ? '0 : k_q;
  assign n_eff = start ? n_cfg : n_q;
  assign emit = k_eff == n_eff - ONE;
  assign last = addr_q == LAST;
`ifdef SPECTRUM_AVERAGER_SATURATE_EN
  localparam int SW = ACC_WIDTH + 1;
  logic [SW-1:0] sum_w;
  logic sat_q;
  assign sum_w = (s1_first_q ? '0 : SW'(rd_data)) + SW'(s1_data_q);
  assign sum = sum_w[ACC_WIDTH] ? '1 : sum_w[ACC_WIDTH-1:0];
  assign sat_flag = sat_q;
  always_ff @(posedge clk) begin
    if (rst || start) sat_q <= 1'b0;
    else if (s1_vld_q && sum_w[ACC_WIDTH]) sat_q <= 1'b1;
  end
`else
  assign sum = (s1_first_q ? '0 : rd_data) + ACC_WIDTH'(s1_data_q);
`endif
  // the first frame of an average ignores stale RAM, so the RAM never needs clearing
  always_ff @(posedge clk) begin
    s1_addr_q <= addr_q;
    s1_data_q <= bus.s_axis_tdata;
    s1_first_q <= k_eff == '0;
    s1_emit_q <= emit;
    s1_last_q <= last;
    s2_addr_q <= s1_addr_q;
    s2_sum_q <= sum;
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      k_q <= '0;
      n_q <= ONE;
      cnt_q <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      m_vld_q <= 1'b0;
      m_last_q <= 1'b0;
      m_data_q <= '0;
    end else begin
      if (bus.s_axis_tvalid) addr_q <= addr_q + FFT_WIDTH'(1);
      state_q <= !avg_en ? IDLE : (state_q == IDLE ? ARM : (start ? RUN : state_q));
      if (proc) k_q <= !last ? k_eff : (emit ? '0 : k_eff + ONE);
      if (start || (proc && last && emit)) n_q <= n_cfg;
      s1_vld_q <= proc;
      s2_vld_q <= s1_vld_q;
      m_vld_q <= s1_vld_q && s1_emit_q;
      m_last_q <= s1_vld_q && s1_emit_q && s1_last_q;
      if (s1_vld_q && s1_emit_q) m_data_q <= sum;
      if (s1_vld_q && s1_emit_q && s1_last_q) cnt_q <= cnt_q + 32'd1;
    end
  end
  accum_ram #(.DEPTH(2**FFT_WIDTH), .WIDTH(ACC_WIDTH)) u_ram (
    .clk(clk),
    .we_i(s2_vld_q),
    .waddr_i(s2_addr_q),
    .wdata_i(s2_sum_q),
    .raddr_i(addr_q),
    .rdata_o(rd_data)
  );
  assign bus.m_axis_tdata = m_data_q;
  assign bus.m_axis_tvalid = m_vld_q;
  assign bus.m_axis_tlast = m_last_q;
  assign n_avg_used = n_q;
  assign avg_count = cnt_q;
endmodule

// File: tb/tb_spectrum_averager.sv
// tb_spectrum_averager: randomized self-checking bench against a frame-level averaging model
module tb_spectrum_averager;
  localparam int FW = 4, NB = 16, DW = 32, NW = 16;
`ifdef SPECTRUM_AVERAGER_SATURATE_EN
  localparam int ACCW = 33;
`else
  localparam int ACCW = 48;
`endif
  localparam longint MAXV = (longint'(1) << ACCW) - 1;
  typedef struct packed { logic [31:0] c; logic [ACCW-1:0] d; logic l; } beat_t;
  logic clk = 1'b0, rst = 1'b1, avg_en = 1'b0;
  logic [NW-1:0] cfg_n_avg = '0;
  logic [NW-1:0] n_avg_used;
  logic [31:0] avg_count;
  int cyc = 0, checks = 0, errors = 0;
  int m_state, m_bin, m_k, m_n, m_cnt;
  bit m_sat;
  longint m_acc [NB];
  beat_t exp_q[$], act_q[$];
  spectrum_averager_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) bus ();
`ifdef SPECTRUM_AVERAGER_SATURATE_EN
  logic sat_flag;
`endif
  spectrum_averager #(.FFT_WIDTH(FW), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .N_AVG_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .avg_en(avg_en), .cfg_n_avg(cfg_n_avg), .bus(bus),
    .n_avg_used(n_avg_used), .avg_count(avg_count)
`ifdef SPECTRUM_AVERAGER_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.m_axis_tvalid === 1'b1) act_q.push_back({32'(cyc), bus.m_axis_tdata, bus.m_axis_tlast});

  // one input cycle of the averaging rules; expected beats appear two cycles after their sample
  task automatic model_step(input bit en, input bit v, input logic [DW-1:0] d);
    longint s;
    if (en && v && (m_state == 2 || (m_state == 1 && m_bin == 0))) begin
      if (m_state == 1) begin
        m_state = 2; m_k = 0; m_sat = 0;
        m_n = (cfg_n_avg == 0) ? 1 : int'(cfg_n_avg);
      end
      s = (m_k == 0 ? 0 : m_acc[m_bin]) + longint'(d);
      if (s > MAXV) begin
`ifdef SPECTRUM_AVERAGER_SATURATE_EN
        s = MAXV; m_sat = 1;
`else
        s = s - MAXV - 1;
`endif
      end
      m_acc[m_bin] = s;
      if (m_k == m_n - 1) begin
        exp_q.push_back({32'(cyc + 2), ACCW'(s), m_bin == NB - 1});
        if (m_bin == NB - 1) m_cnt++;
      end
      if (m_bin == NB - 1) begin
        if (m_k == m_n - 1) begin
          m_k = 0; m_n = (cfg_n_avg == 0) ? 1 : int'(cfg_n_avg);
        end else m_k++;
      end
    end
    if (!en) m_state = 0; else if (m_state == 0) m_state = 1;
    if (v) m_bin = (m_bin + 1) % NB;
  endtask

  task automatic model_reset();
    m_state = 0; m_bin = 0; m_k = 0; m_n = 1; m_cnt = 0; m_sat = 0;
    while (exp_q.size() > 0 && exp_q[$].c > 32'(cyc)) void'(exp_q.pop_back());
  endtask

  task automatic drive(input bit en, input bit v, input logic [DW-1:0] d);
    @(negedge clk);
    avg_en = en; bus.s_axis_tvalid = v; bus.s_axis_tdata = d;
    model_step(en, v, d);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'd7;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset tvalid: got %b expected 0", bus.m_axis_tvalid); end
    if (bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset tlast: got %b expected 0", bus.m_axis_tlast); end
    if (bus.m_axis_tdata !== '0) begin errors++; $display("FAIL reset tdata: got %0h expected 0", bus.m_axis_tdata); end
    if (n_avg_used !== 16'd1) begin errors++; $display("FAIL reset n_avg_used: got %0d expected 1", n_avg_used); end
    if (avg_count !== 32'd0) begin errors++; $display("FAIL reset avg_count: got %0d expected 0", avg_count); end
    model_reset();
    rst = 1'b0; bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic test_basic();
    cfg_n_avg = 16'd4;
    drive(1, 0, 0);
    repeat (4 * NB) drive(1, 1, 32'd128);
    repeat (4) drive(1, 0, 0);
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL basic beats: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic beat %0d: got cyc=%0d data=%0h last=%b expected cyc=%0d data=%0h last=%b", i, act_q[i].c, act_q[i].d, act_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l); end
    end
    checks += 2;
    if (act_q.size() == 0 || act_q[0].d !== ACCW'(512)) begin errors++; $display("FAIL basic sum: got %0d beats expected 512 per bin", act_q.size()); end
    if (avg_count !== 32'(m_cnt)) begin errors++; $display("FAIL basic avg_count: got %0d expected %0d", avg_count, m_cnt); end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_passthrough();
    drive(0, 0, 0);
    cfg_n_avg = 16'd0;
    drive(1, 0, 0);
    repeat (3 * NB + 5) drive(1, 1, DW'(m_bin));
    repeat (4) drive(1, 0, 0);
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL passthrough beats: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL passthrough beat %0d: got cyc=%0d data=%0h last=%b expected cyc=%0d data=%0h last=%b", i, act_q[i].c, act_q[i].d, act_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l); end
    end
    checks += 2;
    if (avg_count !== 32'(m_cnt)) begin errors++; $display("FAIL passthrough avg_count: got %0d expected %0d", avg_count, m_cnt); end
    if (n_avg_used !== 16'd1) begin errors++; $display("FAIL passthrough n_avg_used: got %0d expected 1", n_avg_used); end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_midframe();
    cfg_n_avg = 16'd2;
    for (int i = 0; i < 40 && m_bin != 5; i++) drive(0, 1, $urandom);
    repeat (NB - 5 + 2 * NB) drive(1, 1, $urandom);
    repeat (4) drive(1, 0, 0);
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL midframe beats: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL midframe beat %0d: got cyc=%0d data=%0h last=%b expected cyc=%0d data=%0h last=%b", i, act_q[i].c, act_q[i].d, act_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_cfg_change();
    drive(0, 0, 0);
    while (m_bin != 0) drive(0, 1, 0);
    cfg_n_avg = 16'd4;
    drive(1, 0, 0);
    repeat (NB + 4) drive(1, 1, $urandom_range(0, 1000));
    cfg_n_avg = 16'd2;
    checks++;
    if (n_avg_used !== 16'd4) begin errors++; $display("FAIL cfg_change n_avg_used mid: got %0d expected 4", n_avg_used); end
    repeat (5 * NB - 4) drive(1, 1, $urandom_range(0, 1000));
    repeat (4) drive(1, 0, 0);
    checks += 2;
    if (n_avg_used !== 16'd2) begin errors++; $display("FAIL cfg_change n_avg_used after: got %0d expected 2", n_avg_used); end
    if (act_q.size() != exp_q.size() || act_q.size() != 2 * NB) begin errors++; $display("FAIL cfg_change beats: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL cfg_change beat %0d: got cyc=%0d data=%0h last=%b expected cyc=%0d data=%0h last=%b", i, act_q[i].c, act_q[i].d, act_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_gaps();
    drive(0, 0, 0);
    cfg_n_avg = 16'd2;
    drive(1, 0, 0);
    for (int i = 0; i < 8 * NB; i++) drive(1, (i / 2) % 2 == 0, 32'd128);
    repeat (4) drive(1, 0, 0);
    checks++;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL gaps beats: got %0d expected %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL gaps beat %0d: got cyc=%0d data=%0h last=%b expected cyc=%0d data=%0h last=%b", i, act_q[i].c, act_q[i].d, act_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_random();
    drive(0, 0, 0);
    cfg_n_avg = NW'($urandom_range(0, 3));
    for (int i = 0; i < 300; i++) begin
      if (i == 150) cfg_n_avg = NW'($urandom_range(0, 3));
      drive(1, $urandom_range(0, 3) != 0, $urandom);
    end
    repeat (4) drive(1, 0, 0);
    checks += 2;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL random beats: got %0d expected %0d", act_q.size(), exp_q.size()); end
    if (avg_count !== 32'(m_cnt)) begin errors++; $display("FAIL random avg_count: got %0d expected %0d", avg_count, m_cnt); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL random beat %0d: got cyc=%0d data=%0h last=%b expected cyc=%0d data=%0h last=%b", i, act_q[i].c, act_q[i].d, act_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_rst_mid();
    drive(0, 0, 0);
    cfg_n_avg = 16'd3;
    for (int i = 0; i < 200 && !(m_state == 2 && m_k == 2 && m_bin == 7); i++) drive(1, 1, $urandom_range(0, 5000));
    @(negedge clk);
    rst = 1'b1; avg_en = 1'b0; bus.s_axis_tvalid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid tvalid: got %b expected 0", bus.m_axis_tvalid); end
    if (avg_count !== 32'd0) begin errors++; $display("FAIL rst_mid avg_count: got %0d expected 0", avg_count); end
    if (n_avg_used !== 16'd1) begin errors++; $display("FAIL rst_mid n_avg_used: got %0d expected 1", n_avg_used); end
    cfg_n_avg = 16'd2;
    drive(1, 0, 0);
    repeat (3 * NB) drive(1, 1, $urandom_range(0, 5000));
    repeat (4) drive(1, 0, 0);
    checks += 2;
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid beats: got %0d expected %0d", act_q.size(), exp_q.size()); end
    if (avg_count !== 32'(m_cnt)) begin errors++; $display("FAIL rst_mid avg_count after: got %0d expected %0d", avg_count, m_cnt); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid beat %0d: got cyc=%0d data=%0h last=%b expected cyc=%0d data=%0h last=%b", i, act_q[i].c, act_q[i].d, act_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l); end
    end
    exp_q.delete(); act_q.delete();
  endtask

`ifdef SPECTRUM_AVERAGER_SATURATE_EN
  task automatic test_sat();
    drive(0, 0, 0);
    cfg_n_avg = 16'd4;
    drive(1, 0, 0);
    repeat (5 * NB) drive(1, 1, 32'hFFFF_FFFF);
    repeat (4) drive(1, 0, 0);
    checks += 3;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat flag set: got %b expected 1", sat_flag); end
    if (act_q.size() == 0 || act_q[0].d !== ACCW'(MAXV)) begin errors++; $display("FAIL sat clamp: got %0d beats, expected data %0h", act_q.size(), MAXV); end
    if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL sat beats: got %0d expected %0d", act_q.size(), exp_q.size()); end
    drive(0, 0, 0);
    cfg_n_avg = 16'd1;
    drive(1, 0, 0);
    repeat (NB + 2) drive(1, 1, 32'd3);
    checks++;
    if (sat_flag !== 1'(m_sat)) begin errors++; $display("FAIL sat flag clear: got %b expected %b", sat_flag, m_sat); end
    exp_q.delete(); act_q.delete();
  endtask
`endif

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    m_acc = '{default: 0};
    test_reset();
    test_basic();
    test_passthrough();
    test_midframe();
    test_cfg_change();
    test_gaps();
    test_random();
    test_rst_mid();
`ifdef SPECTRUM_AVERAGER_SATURATE_EN
    test_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
